dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Byte-addressed, little-endian data-memory responder. It serves load/store requests issued by the execute/memory stage.
- Supports byte, half and word sizes, with sign or zero extension.
- Misaligned accesses that cross a word boundary are split into two word-array cycles by an FSM, and `req_ready` stalls the pipeline meanwhile.
- Replaces the single-cycle data memory on the pipeline's memory-stage bus.

Parameters:
- ADDR_W, 10, byte-address width; storage depth is 2^(ADDR_W-2) 32-bit words.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal (funct3[1:0]).
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend (funct3[2]).
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-justified.
- rsp_valid  output  1  single-cycle response pulse.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_split  output  1  response came from a two-word (boundary-crossing) access.
- rsp_err  output  1  illegal size; no memory access was performed.

Behaviour:
Reset:
- Clock and reset: clk rising edge; rst_n asynchronous, active-low.
- While rst_n = 0: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_split = 0, rsp_err = 0, FSM = IDLE.
- Storage contents are not reset.

Handshake:
- A request is accepted on a rising edge when req_valid & req_ready.
- req_ready = 1 exactly when the FSM is in IDLE.
- No response backpressure: rsp_valid is high for exactly one cycle per accepted request.

Access span:
- Offset o = addr[1:0], span n = 1 / 2 / 4 bytes by size.
- Crossing when o + n > 4. Possible cases: half at o = 3, word at o = 1..3.

FSM states IDLE and SECOND:
- IDLE, accept of an aligned or non-crossing request:
  - Store: write the byte lanes for bytes o..o+n-1 of word addr[ADDR_W-1:2] at the accept edge.
  - Load: read that word.
  - Response registered: rsp_valid in the next cycle. The FSM stays in IDLE, so throughput is 1 request per cycle and back-to-back accepts are allowed.
- IDLE, accept of a crossing request:
  - Perform the first-word part at the accept edge, latching the request, then go to SECOND.
  - First part covers lanes o..3 of word w; store writes low data bytes 0..(3-o).
- SECOND, one cycle, req_ready = 0:
  - Access word w+1, lanes 0..(o+n-5).
  - Store writes the remaining data bytes.
  - Load merges with the first part's bytes.
  - Return to IDLE at the edge; rsp_valid in the following cycle with rsp_split = 1.
- Latency: non-crossing = 1 cycle after accept; crossing = 2 cycles after accept.
- Illegal size 11: no write and no read; rsp_valid next cycle with rsp_err = 1, rsp_rdata = 0; stays in IDLE.

Data and addressing rules:
- Word wrap: w+1 is modulo 2^(ADDR_W-2), so the last word wraps to word 0.
- Load extension: byte/half are extended from bit 7/15 per req_unsigned; word ignores req_unsigned.
- Store data: only req_wdata[8n-1:0] is used.
- Store responses: rsp_rdata = 0.

Ordering and reset mid-operation:
- Ordering: a load accepted the cycle after a store to the same bytes returns the new data, because the write commits at its accept edge.
- Reset in SECOND aborts the access: the second-half write is not performed, and no rsp_valid is produced after rst_n deasserts.
- rsp_rdata holds its last value between responses.

Test Plan:
- Aligned word: store 0xDEADBEEF at 0x010, then load word at 0x010 → rsp_rdata 0xDEADBEEF, rsp_split 0, rsp_valid 1 cycle after each accept.
- Byte/half extension: after the store above:
  - lb 0x013 → 0xFFFFFFDE
  - lbu 0x013 → 0x000000DE
  - lh 0x010 → 0xFFFFBEEF
  - lhu 0x012 → 0x0000DEAD
- Crossing word:
  - Setup: word 0x020 = 0x44332211, word 0x024 = 0x88776655.
  - lw 0x022 → 0x66554433, rsp_split 1; req_ready low exactly one cycle; rsp_valid 2 cycles after accept.
- Crossing store and wrap (ADDR_W = 10):
  - sh 0xAABB at 0x3FF → byte 0x3FF = 0xBB, byte 0x000 = 0xAA.
  - lhu 0x3FF → 0x0000AABB.
- Back-to-back and illegal:
  - Three aligned requests on consecutive cycles → three consecutive rsp_valid pulses, in order.
  - size = 11 store → rsp_err 1, memory unchanged.
- Reset in SECOND: crossing sw 0x11223344 at 0x041, pulse rst_n low during SECOND → no rsp_valid; word 0x044 unchanged; bytes 0x041..0x043 = 0x44, 0x33, 0x22; req_ready = 0 while reset is asserted.

Source files
------------

// File: rtl/dmem_responder.sv
// Byte-addressed little-endian data memory for the memory stage. Loads and stores of
// byte/half/word; accesses that straddle a word boundary take a second word cycle.
module dmem_responder #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_split,
    output logic              rsp_err
);

    localparam int DATA_W = 32;
    localparam int WIDX_W = ADDR_W - 2;
    localparam int DEPTH  = 1 << WIDX_W;

    typedef enum logic {IDLE, SECOND} state_t;

    state_t state, nextState;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept, illegal, crossing;
    logic [1:0]        offs;
    logic [WIDX_W-1:0] wordIdx;
    logic [7:0]        sizeMask, be8;
    logic [63:0]       wd64;

    logic              memWe;
    logic [3:0]        memBe;
    logic [WIDX_W-1:0] memIdx;
    logic [DATA_W-1:0] memWd, rdWord;

    logic [1:0]        offs_p1, size_p1;
    logic              uns_p1, we_p1;
    logic [WIDX_W-1:0] wNext_p1;
    logic [DATA_W-1:0] wdHi_p1, loWord_p1;
    logic [3:0]        beHi_p1;

    // Align a two-word window to the access offset and extend to 32 bits.
    function automatic logic [31:0] extendLoad(input logic [63:0] win, input logic [1:0] byteOff,
                                               input logic [1:0] sz, input logic zext);
        logic [31:0] lo;
        lo = 32'(win >> {byteOff, 3'b000});
        case (sz)
            2'b00:   extendLoad = zext ? {24'b0, lo[7:0]}  : {{24{lo[7]}}, lo[7:0]};
            2'b01:   extendLoad = zext ? {16'b0, lo[15:0]} : {{16{lo[15]}}, lo[15:0]};
            default: extendLoad = lo;
        endcase
    endfunction

    assign req_ready = rst_n && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign offs      = req_addr[1:0];
    assign wordIdx   = req_addr[ADDR_W-1:2];
    assign illegal   = (req_size == 2'b11);
    assign crossing  = ((req_size == 2'b01) && (offs == 2'd3)) ||
                       ((req_size == 2'b10) && (offs != 2'd0));

    always_comb begin
        case (req_size)
            2'b00:   sizeMask = 8'h01;
            2'b01:   sizeMask = 8'h03;
            2'b10:   sizeMask = 8'h0F;
            default: sizeMask = 8'h00;
        endcase
    end

    // Lanes and data over an 8-byte window: low half is word w, high half is word w+1.
    assign be8  = sizeMask << offs;
    assign wd64 = {32'b0, req_wdata} << {offs, 3'b000};

    always_comb begin
        nextState = state;
        memWe     = 1'b0;
        memBe     = be8[3:0];
        memIdx    = wordIdx;
        memWd     = wd64[31:0];
        case (state)
            IDLE: begin
                if (accept && !illegal) begin
                    memWe = req_we;
                    if (crossing) nextState = SECOND;
                end
            end
            SECOND: begin
                memWe     = we_p1;
                memBe     = beHi_p1;
                memIdx    = wNext_p1;
                memWd     = wdHi_p1;
                nextState = IDLE;
            end
        endcase
    end

    assign rdWord = mem[memIdx];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (memWe && memBe[b]) mem[memIdx][8*b +: 8] <= memWd[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nextState;
    end

    // Stage p1: first-word context held for the SECOND cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            offs_p1    <= offs;
            size_p1    <= req_size;
            uns_p1     <= req_unsigned;
            we_p1      <= req_we;
            wNext_p1   <= wordIdx + 1'b1;
            wdHi_p1    <= wd64[63:32];
            beHi_p1    <= be8[7:4];
            loWord_p1  <= rdWord;
        end
    end

    // Registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_split <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == SECOND) begin
                rsp_valid <= 1'b1;
                rsp_split <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_rdata <= we_p1 ? '0 : extendLoad({rdWord, loWord_p1}, offs_p1, size_p1, uns_p1);
            end else if (accept && !crossing) begin
                rsp_valid <= 1'b1;
                rsp_split <= 1'b0;
                rsp_err   <= illegal;
                rsp_rdata <= (req_we || illegal) ? '0
                             : extendLoad({32'b0, rdWord}, offs, req_size, req_unsigned);
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected responses,
// a negedge monitor pops and compares data, flags and arrival cycle.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_split;
    logic        rsp_err;

    localparam logic [1:0] SZB = 2'b00, SZH = 2'b01, SZW = 2'b10, SZX = 2'b11;

    dmem_responder #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_split(rsp_split), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic        s;
        logic        e;
        int          c;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rsp_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected rsp: data %h split %b err %b cycle %0d",
                         rsp_rdata, rsp_split, rsp_err, cyc);
            end else begin
                cur = sb.pop_front();
                if (rsp_rdata !== cur.d || rsp_split !== cur.s || rsp_err !== cur.e || cyc != cur.c) begin
                    errors++;
                    $display("FAIL rsp: got data %h split %b err %b cycle %0d, want data %h split %b err %b cycle %0d",
                             rsp_rdata, rsp_split, rsp_err, cyc, cur.d, cur.s, cur.e, cur.c);
                end
            end
        end
    end

    // Called between edges; returns 1 time unit after the accept edge with req_valid still high.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [9:0] addr, input logic [31:0] wd,
                         input logic [31:0] expD, input logic expS, input logic expE,
                         input bit push);
        int guard;
        exp_t x;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready timeout: got %b want 1", req_ready);
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        if (push) begin
            x.d = expD; x.s = expS; x.e = expE; x.c = cyc + 1 + int'(expS);
            sb.push_back(x);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        #3;
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_split", 32'(rsp_split), 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready after reset", 32'(req_ready), 32'd1);

        // Aligned store then back-to-back loads, incl. load right after store
        issue(1, SZW, 0, 10'h010, 32'hDEADBEEF, 32'h0, 0, 0, 1);
        issue(0, SZW, 0, 10'h010, 32'h0, 32'hDEADBEEF, 0, 0, 1);
        issue(0, SZB, 0, 10'h013, 32'h0, 32'hFFFFFFDE, 0, 0, 1);
        issue(0, SZB, 1, 10'h013, 32'h0, 32'h000000DE, 0, 0, 1);
        issue(0, SZH, 0, 10'h010, 32'h0, 32'hFFFFBEEF, 0, 0, 1);
        issue(0, SZH, 1, 10'h012, 32'h0, 32'h0000DEAD, 0, 0, 1);
        issue(0, SZB, 0, 10'h010, 32'h0, 32'hFFFFFFEF, 0, 0, 1);
        issue(0, SZB, 1, 10'h011, 32'h0, 32'h000000BE, 0, 0, 1);

        // Crossing word load
        issue(1, SZW, 0, 10'h020, 32'h44332211, 32'h0, 0, 0, 1);
        issue(1, SZW, 0, 10'h024, 32'h88776655, 32'h0, 0, 0, 1);
        issue(0, SZW, 0, 10'h022, 32'h0, 32'h66554433, 1, 0, 1);
        chk("crossing ready low", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("crossing ready back", 32'(req_ready), 32'd1);

        // Crossing half store with wrap to word 0; upper wdata ignored
        issue(1, SZH, 0, 10'h3FF, 32'h1234AABB, 32'h0, 1, 0, 1);
        issue(0, SZH, 1, 10'h3FF, 32'h0, 32'h0000AABB, 1, 0, 1);
        issue(0, SZH, 0, 10'h3FF, 32'h0, 32'hFFFFAABB, 1, 0, 1);
        issue(0, SZB, 1, 10'h3FF, 32'h0, 32'h000000BB, 0, 0, 1);
        issue(0, SZB, 1, 10'h000, 32'h0, 32'h000000AA, 0, 0, 1);

        // Illegal size: error response, memory untouched
        issue(1, SZX, 0, 10'h010, 32'hFFFFFFFF, 32'h0, 0, 1, 1);
        issue(0, SZX, 1, 10'h013, 32'h0, 32'h0, 0, 1, 1);
        issue(0, SZW, 0, 10'h010, 32'h0, 32'hDEADBEEF, 0, 0, 1);

        // Crossing word store at offset 3, then readback across both words
        issue(1, SZW, 0, 10'h023, 32'hCAFEF00D, 32'h0, 1, 0, 1);
        issue(0, SZW, 0, 10'h020, 32'h0, 32'h0D332211, 0, 0, 1);
        issue(0, SZW, 0, 10'h024, 32'h0, 32'h88CAFEF0, 0, 0, 1);
        issue(0, SZH, 0, 10'h023, 32'h0, 32'hFFFFF00D, 1, 0, 1);
        issue(0, SZW, 0, 10'h022, 32'h0, 32'hFEF00D33, 1, 0, 1);

        // Reset during SECOND aborts the second-word write and the response
        issue(1, SZW, 0, 10'h040, 32'h00000099, 32'h0, 0, 0, 1);
        issue(1, SZW, 0, 10'h044, 32'h5A5A5A5A, 32'h0, 0, 0, 1);
        issue(1, SZW, 0, 10'h041, 32'h11223344, 32'h0, 1, 0, 0);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid-reset ready", 32'(req_ready), 32'd0);
        chk("mid-reset rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("held-reset ready", 32'(req_ready), 32'd0);
        chk("held-reset rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post-reset rsp_valid", 32'(rsp_valid), 32'd0);
        end
        issue(0, SZW, 0, 10'h044, 32'h0, 32'h5A5A5A5A, 0, 0, 1);
        issue(0, SZW, 0, 10'h040, 32'h0, 32'h22334499, 0, 0, 1);
        req_valid = 1'b0;

        guard = 0;
        while (sb.size() != 0 && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
